dithering_rgb: RTL and testbench

DITHERING_RGB -- requirements
Module: dithering_rgb

---
 rtl/dithering_pkg.sv | 14 +
 rtl/dither_channel.sv | 75 +++++++
 rtl/dithering_rgb.sv | 88 ++++++++
 tb/tb_dithering_rgb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dithering_pkg.sv
// Shared definitions for the RGB dithering block: quantisation mode
// encoding and default channel geometry.
package dithering_pkg;

    typedef enum logic {
        TRUNC   = 1'b0,
        DIFFUSE = 1'b1
    } mode_e;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_OUT_W = 4;
    localparam int DEF_N_CH  = 3;

endpackage

// File: rtl/dither_channel.sv
// One colour channel of the ditherer: error-diffusion quantiser with its own
// signed carry-error register, updated only on accepted beats.
module dither_channel
    import dithering_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int THRESHOLD = 2**(IN_W-OUT_W-1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_e            mode,
    input  logic             visible,
    input  logic             sol,
    input  logic [IN_W-1:0]  in_val,
    output logic [OUT_W-1:0] q,
    output logic             sat
);

    localparam int S  = IN_W - OUT_W;
    localparam int EW = S + 2;
    localparam int SW = IN_W + 2;
    localparam logic [S:0]           THR_V = (S+1)'(THRESHOLD);
    localparam logic signed [SW-1:0] MAX_V = {2'b00, {IN_W{1'b1}}};

    logic signed [EW-1:0] e_reg, e_next, e_used;
    logic signed [SW-1:0] sum, diff;
    logic [IN_W-1:0]      clamped;
    logic [S-1:0]         resid;
    logic [OUT_W-1:0]     q_next;

    always_comb begin
        e_used  = sol ? '0 : e_reg;
        sum     = $signed({2'b00, in_val}) + $signed({{OUT_W{e_used[EW-1]}}, e_used});
        sat     = 1'b0;
        clamped = sum[IN_W-1:0];
        if (sum[SW-1]) begin
            clamped = '0;
            sat     = 1'b1;
        end else if (sum > MAX_V) begin
            clamped = '1;
            sat     = 1'b1;
        end

        q_next = clamped[IN_W-1:S];
        resid  = clamped[S-1:0];
        diff   = '0;
        e_next = '0;
        if (mode == DIFFUSE) begin
            // Never round past full scale; the overshoot stays in the error.
            if (({1'b0, resid} >= THR_V) && (q_next != {OUT_W{1'b1}}))
                q_next = q_next + OUT_W'(1);
            diff   = $signed({2'b00, clamped}) - $signed({2'b00, q_next, {S{1'b0}}});
            e_next = EW'(diff);
        end else begin
            q_next = in_val[IN_W-1:S];
        end

        if (!visible) begin
            q_next = '0;
            e_next = '0;
            sat    = 1'b0;
        end
        q = q_next;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            e_reg <= '0;
        else if (en)
            e_reg <= e_next;
    end

endmodule

// File: rtl/dithering_rgb.sv
// Multi-channel RGB ditherer with a single-stage valid/ready output register.
// Defining DITHER_STATUS_EN adds the sat_count saturation-event counter port.
module dithering_rgb
    import dithering_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int N_CH      = DEF_N_CH,
    parameter int THRESHOLD = 2**(IN_W-OUT_W-1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*IN_W-1:0]  in_pixel,
    input  logic                  in_visible,
    input  logic                  in_sol,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*OUT_W-1:0] out_pixel
`ifdef DITHER_STATUS_EN
    ,
    output logic [15:0]           sat_count
`endif
);

    logic                  accept;
    logic                  out_valid_reg;
    logic [N_CH*OUT_W-1:0] out_pixel_reg;
    logic [N_CH*OUT_W-1:0] q_all;
    logic [N_CH-1:0]       sat_vec;

    // Gated by rst so nothing is offered upstream while reset is held.
    assign in_ready  = rst && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign out_pixel = out_pixel_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : gen_ch
            dither_channel #(
                .IN_W      (IN_W),
                .OUT_W     (OUT_W),
                .THRESHOLD (THRESHOLD)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .en      (accept),
                .mode    (mode_e'(mode)),
                .visible (in_visible),
                .sol     (in_sol),
                .in_val  (in_pixel[gi*IN_W +: IN_W]),
                .q       (q_all[gi*OUT_W +: OUT_W]),
                .sat     (sat_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_pixel_reg <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_pixel_reg <= q_all;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef DITHER_STATUS_EN
    logic [15:0] sat_count_reg;

    always_ff @(posedge clk) begin
        if (!rst)
            sat_count_reg <= '0;
        else if (accept && (|sat_vec) && (sat_count_reg != 16'hFFFF))
            sat_count_reg <= sat_count_reg + 16'd1;
    end

    assign sat_count = sat_count_reg;
`else
    logic unused_sat;
    assign unused_sat = ^sat_vec;
`endif

endmodule

// File: tb/tb_dithering_rgb.sv
// Self-checking bench for dithering_rgb: directed scenarios then randomized
// traffic, all compared against an arithmetic reference model.
module tb_dithering_rgb;

    localparam int IN_W  = 8;
    localparam int OUT_W = 4;
    localparam int N_CH  = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  mode = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N_CH*IN_W-1:0]  in_pixel = '0;
    logic                  in_visible = 1'b1;
    logic                  in_sol = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [N_CH*OUT_W-1:0] out_pixel;
`ifdef DITHER_STATUS_EN
    logic [15:0]           sat_count;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    int              m_e [N_CH];
    logic            m_valid;
    logic [11:0]     m_pixel;
    int              m_sat;

    dithering_rgb #(.IN_W(IN_W), .OUT_W(OUT_W), .N_CH(N_CH), .THRESHOLD(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_visible (in_visible),
        .in_sol     (in_sol),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel)
`ifdef DITHER_STATUS_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) m_e[ch] = 0;
        m_valid = 1'b0;
        m_pixel = '0;
        m_sat   = 0;
    endtask

    // Quantise one accepted beat with plain integer arithmetic.
    task automatic model_beat(input logic [23:0] pix, input logic vis, input logic sol, input logic md);
        logic [11:0] px;
        bit any;
        px  = '0;
        any = 0;
        for (int ch = 0; ch < N_CH; ch++) begin
            int v, s, c, q, r;
            v = int'((pix >> (8*ch)) & 24'hFF);
            q = 0;
            if (!vis) begin
                m_e[ch] = 0;
            end else begin
                s = v + (sol ? 0 : m_e[ch]);
                if (s < 0) begin c = 0; any = 1; end
                else if (s > 255) begin c = 255; any = 1; end
                else c = s;
                if (md) begin
                    q = c / 16;
                    r = c % 16;
                    if (r >= 8 && q != 15) q = q + 1;
                    m_e[ch] = c - q*16;
                end else begin
                    q = v / 16;
                    m_e[ch] = 0;
                end
            end
            px[4*ch +: 4] = 4'(q);
        end
        m_pixel = px;
        m_valid = 1'b1;
        if (any && m_sat < 65535) m_sat++;
    endtask

    // One clock cycle: drive at negedge, check ready, check outputs after the edge.
    task automatic cycle(input logic iv, input logic [23:0] pix, input logic vis,
                         input logic sol, input logic md, input logic ordy);
        logic exp_rdy, acc;
        @(negedge clk);
        in_valid = iv; in_pixel = pix; in_visible = vis; in_sol = sol; mode = md; out_ready = ordy;
        #1;
        exp_rdy = !m_valid || ordy;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = iv && exp_rdy;
        if (acc) model_beat(pix, vis, sol, md);
        else if (ordy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) check("out_pixel", {20'd0, out_pixel}, {20'd0, m_pixel});
`ifdef DITHER_STATUS_EN
        check("sat_count", {16'd0, sat_count}, m_sat);
`endif
        if (acc)
            $display("[TB] beat in=%06h vis=%0b sol=%0b mode=%0b -> out=%03h", pix, vis, sol, md, out_pixel);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_pixel", {20'd0, out_pixel}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef DITHER_STATUS_EN
        check("rst_sat_count", {16'd0, sat_count}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    function automatic logic [7:0] pick_chan();
        case ($urandom_range(0, 3))
            0: return 8'($urandom_range(0, 7));
            1: return 8'($urandom_range(248, 255));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();

        // Constant 0x08 on ch0 alternates 1,0,1,0
        cycle(1, 24'h000008, 1, 1, 1, 1); check("c08_b1", {28'd0, out_pixel[3:0]}, 32'd1);
        cycle(1, 24'h000008, 1, 0, 1, 1); check("c08_b2", {28'd0, out_pixel[3:0]}, 32'd0);
        cycle(1, 24'h000008, 1, 0, 1, 1); check("c08_b3", {28'd0, out_pixel[3:0]}, 32'd1);
        cycle(1, 24'h000008, 1, 0, 1, 1); check("c08_b4", {28'd0, out_pixel[3:0]}, 32'd0);

        // Full scale saturates from the second beat on
        cycle(1, 24'hFFFFFF, 1, 1, 1, 1); check("cff_b1", {20'd0, out_pixel}, 32'hFFF);
        cycle(1, 24'hFFFFFF, 1, 0, 1, 1); check("cff_b2", {20'd0, out_pixel}, 32'hFFF);
        cycle(1, 24'hFFFFFF, 1, 0, 1, 1); check("cff_b3", {20'd0, out_pixel}, 32'hFFF);

        // 0x04 x3: 0,1,0 with low clamp on the third beat
        cycle(1, 24'h000004, 1, 1, 1, 1); check("c04_b1", {28'd0, out_pixel[3:0]}, 32'd0);
        cycle(1, 24'h000004, 1, 0, 1, 1); check("c04_b2", {28'd0, out_pixel[3:0]}, 32'd1);
        cycle(1, 24'h000004, 1, 0, 1, 1); check("c04_b3", {28'd0, out_pixel[3:0]}, 32'd0);

        // Back-pressure: output held, error untouched, then resumes
        cycle(1, 24'h000008, 1, 1, 1, 1); check("stall_b1", {28'd0, out_pixel[3:0]}, 32'd1);
        repeat (3) begin
            cycle(1, 24'h000008, 1, 0, 1, 0);
            check("stall_hold", {28'd0, out_pixel[3:0]}, 32'd1);
        end
        cycle(1, 24'h000008, 1, 0, 1, 1); check("stall_b2", {28'd0, out_pixel[3:0]}, 32'd0);
        cycle(1, 24'h000008, 1, 0, 1, 1); check("stall_b3", {28'd0, out_pixel[3:0]}, 32'd1);
        cycle(0, 24'h000000, 1, 0, 1, 1);

        // Invisible beat clears the error; then truncate mode
        cycle(1, 24'h000008, 1, 1, 1, 1); check("vis_b1", {28'd0, out_pixel[3:0]}, 32'd1);
        cycle(1, 24'h000008, 0, 0, 1, 1); check("vis_blank", {20'd0, out_pixel}, 32'd0);
        cycle(1, 24'h000008, 1, 0, 1, 1); check("vis_b3", {28'd0, out_pixel[3:0]}, 32'd1);
        cycle(1, 24'h00008C, 0, 0, 1, 1);
        cycle(1, 24'h00008C, 1, 0, 0, 1); check("trunc_8c", {28'd0, out_pixel[3:0]}, 32'd8);

        // Reset while holding a valid output
        cycle(1, 24'h000008, 1, 1, 1, 0);
        do_reset();
        cycle(1, 24'h000008, 1, 0, 1, 1); check("post_rst", {28'd0, out_pixel[3:0]}, 32'd1);

        // Randomized traffic with back-pressure, blanking and mode changes
        for (int i = 0; i < 400; i++) begin
            logic [23:0] pix;
            pix = {pick_chan(), pick_chan(), pick_chan()};
            cycle($urandom_range(0, 3) != 0, pix, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0);
        end
        cycle(0, 24'h000000, 1, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
